// File: rtl/bch_error_apply_if.sv
// Stream bundle for bch_error_apply: buffered codeword data in, locator error
// flags in, corrected data and per-codeword status out.
interface bch_error_apply_if #(
    parameter int BITS  = 1,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  in_data;
    logic             in_last;
    logic             err_valid;
    logic             err_first;
    logic             err_last;
    logic [BITS-1:0]  err;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic [BITS-1:0]  out_data;
    logic [CNT_W-1:0] err_count;
    logic             underflow;
    logic             sync_err;

    modport master (
        output in_valid, in_data, in_last, err_valid, err_first, err_last, err,
        input  in_ready, out_valid, out_first, out_last, out_data, err_count,
               underflow, sync_err
    );

    modport slave (
        input  in_valid, in_data, in_last, err_valid, err_first, err_last, err,
        output in_ready, out_valid, out_first, out_last, out_data, err_count,
               underflow, sync_err
    );
endinterface

// File: rtl/bch_error_apply.sv
// Buffers codeword data until the Chien locator streams its error flags, then
// XORs them in and reports the number of corrected bits per codeword.
module bch_error_apply #(
    parameter int BITS  = 1,
    parameter int DEPTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    bch_error_apply_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          OW      = AW + 1;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic [BITS:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [OW-1:0]    r_count;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_err_count;
    logic [BITS-1:0]  r_out_data;
    logic             r_out_valid;
    logic             r_out_first;
    logic             r_out_last;
    logic             r_underflow;
    logic             r_sync_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [BITS:0]    w_head;
    logic [31:0]      w_pc;
    logic [31:0]      w_total;
    logic [CNT_W-1:0] w_sum;

    assign w_full  = (r_count == OW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = bus.err_valid && !w_empty;
    assign w_head  = w_empty ? '0 : r_mem[r_rptr];

    always_comb begin
        w_pc = '0;
        for (int unsigned i = 0; i < BITS; i++) begin
            w_pc = w_pc + 32'(bus.err[i]);
        end
    end

    // Summed in 32 bits so saturation sees the true total before truncation.
    assign w_total = (bus.err_first ? 32'd0 : 32'(r_acc)) + w_pc;
    assign w_sum   = (w_total > CNT_MAX) ? '1 : w_total[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.in_last, bus.in_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_err_count <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_underflow <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OW'(1);
                2'b01:   r_count <= r_count - OW'(1);
                default: ;
            endcase

            r_out_valid <= bus.err_valid;
            r_out_first <= bus.err_valid && bus.err_first;
            r_out_last  <= bus.err_valid && bus.err_last;
            if (bus.err_valid) begin
                r_out_data <= w_head[BITS-1:0] ^ bus.err;
                r_acc      <= w_sum;
                if (bus.err_last) begin
                    r_err_count <= w_sum;
                end
                // Empty FIFO: the flags pass through alone; misaligned last is only flagged.
                if (!w_pop) begin
                    r_underflow <= 1'b1;
                end else if (w_head[BITS] != bus.err_last) begin
                    r_sync_err <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_first = r_out_first;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_data;
    assign bus.err_count = r_err_count;
    assign bus.underflow = r_underflow;
    assign bus.sync_err  = r_sync_err;
endmodule

// File: tb/tb_bch_error_apply.sv
// Scoreboard bench: two instances (4-bit/8-bit count and 1-bit/2-bit count)
// checked against a queue-based transaction model.
module tb_bch_error_apply;
    typedef struct packed {
        logic       first;
        logic       last;
        logic [3:0] data;
        logic [7:0] cnt;
        logic       uf;
        logic       se;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    bch_error_apply_if #(.BITS(4), .CNT_W(8)) a_if ();
    bch_error_apply_if #(.BITS(1), .CNT_W(2)) b_if ();

    bch_error_apply #(.BITS(4), .DEPTH(16), .CNT_W(8)) u_a (.clk(clk), .reset(reset), .bus(a_if));
    bch_error_apply #(.BITS(1), .DEPTH(16), .CNT_W(2)) u_b (.clk(clk), .reset(reset), .bus(b_if));

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sb0[$];
    exp_t       sb1[$];
    logic [4:0] mq0[$];
    logic [4:0] mq1[$];
    int         acc[2];
    int         cnt[2];
    bit         uf[2];
    bit         se[2];
    logic [4:0] pd[$];
    logic [5:0] pe[$];
    logic [3:0] last0 = '0;
    logic [3:0] last1 = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t x;
        if (reset) begin
            last0 = '0;
        end else if (a_if.out_valid) begin
            if (sb0.size() == 0) begin
                check("a_unexpected_beat", 1, 0);
            end else begin
                x = sb0.pop_front();
                check("a_out_first", a_if.out_first, x.first);
                check("a_out_last", a_if.out_last, x.last);
                check("a_out_data", a_if.out_data, x.data);
                check("a_err_count", a_if.err_count, x.cnt);
                check("a_underflow", a_if.underflow, x.uf);
                check("a_sync_err", a_if.sync_err, x.se);
                last0 = x.data;
            end
        end else begin
            check("a_data_hold", a_if.out_data, last0);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t x;
        if (reset) begin
            last1 = '0;
        end else if (b_if.out_valid) begin
            if (sb1.size() == 0) begin
                check("b_unexpected_beat", 1, 0);
            end else begin
                x = sb1.pop_front();
                check("b_out_first", b_if.out_first, x.first);
                check("b_out_last", b_if.out_last, x.last);
                check("b_out_data", b_if.out_data, x.data);
                check("b_err_count", b_if.err_count, x.cnt);
                check("b_underflow", b_if.underflow, x.uf);
                check("b_sync_err", b_if.sync_err, x.se);
                last1 = x.data;
            end
        end else begin
            check("b_data_hold", b_if.out_data, last1);
        end
    end

    // One clock of stimulus on DUT d; the model predicts the response from its own queue.
    task automatic step(input int d, input bit iv, input logic [4:0] din, input bit ev,
                        input logic [5:0] ein, output bit accepted);
        exp_t       x;
        logic [4:0] ent;
        logic [3:0] m;
        int         sz;
        int         mx;
        m  = (d == 0) ? 4'hF : 4'h1;
        mx = (d == 0) ? 255 : 3;
        sz = (d == 0) ? mq0.size() : mq1.size();
        if (d == 0) begin
            a_if.in_valid = iv;  a_if.in_data = din[3:0]; a_if.in_last = din[4];
            a_if.err_valid = ev; a_if.err_first = ein[5]; a_if.err_last = ein[4];
            a_if.err = ein[3:0];
            check("a_in_ready", a_if.in_ready, (sz < 16));
        end else begin
            b_if.in_valid = iv;  b_if.in_data = din[0]; b_if.in_last = din[4];
            b_if.err_valid = ev; b_if.err_first = ein[5]; b_if.err_last = ein[4];
            b_if.err = ein[0];
            check("b_in_ready", b_if.in_ready, (sz < 16));
        end
        if (ev) begin
            x = '0;
            x.first = ein[5];
            x.last  = ein[4];
            if (sz > 0) begin
                ent = (d == 0) ? mq0.pop_front() : mq1.pop_front();
                x.data = (ent[3:0] ^ ein[3:0]) & m;
                if (ent[4] != ein[4]) se[d] = 1'b1;
            end else begin
                x.data = ein[3:0] & m;
                uf[d] = 1'b1;
            end
            acc[d] = (ein[5] ? 0 : acc[d]) + $countones(ein[3:0] & m);
            if (acc[d] > mx) acc[d] = mx;
            if (ein[4]) cnt[d] = acc[d];
            x.cnt = 8'(cnt[d]);
            x.uf  = uf[d];
            x.se  = se[d];
            if (d == 0) sb0.push_back(x); else sb1.push_back(x);
        end
        accepted = iv && (sz < 16);
        if (accepted) begin
            if (d == 0) mq0.push_back({din[4], din[3:0] & m});
            else        mq1.push_back({din[4], din[3:0] & m});
        end
        @(posedge clk);
        #1;
        if (d == 0) begin
            a_if.in_valid = 1'b0; a_if.err_valid = 1'b0;
        end else begin
            b_if.in_valid = 1'b0; b_if.err_valid = 1'b0;
        end
    endtask

    task automatic idle(input int d);
        bit ok;
        step(d, 1'b0, '0, 1'b0, '0, ok);
    endtask

    task automatic add_cw(input int len, input int pct);
        logic [3:0] e;
        for (int i = 0; i < len; i++) begin
            pd.push_back({(i == len - 1), 4'($urandom)});
            e = ($urandom_range(99) < pct) ? 4'($urandom) : 4'h0;
            pe.push_back({(i == 0), (i == len - 1), e});
        end
    endtask

    // Random interleave of data pushes and locator beats; locator only fires on buffered data.
    task automatic run_stream(input int d, input int budget);
        int         cyc;
        int         sz;
        bit         iv;
        bit         ev;
        bit         ok;
        logic [4:0] din;
        logic [5:0] ein;
        cyc = 0;
        while ((pd.size() > 0 || pe.size() > 0) && cyc < budget) begin
            sz  = (d == 0) ? mq0.size() : mq1.size();
            iv  = (pd.size() > 0) && ($urandom_range(3) != 0);
            ev  = (pe.size() > 0) && (sz > 0) && ($urandom_range(2) != 0);
            din = iv ? pd[0] : '0;
            ein = ev ? pe[0] : '0;
            step(d, iv, din, ev, ein, ok);
            if (ok) void'(pd.pop_front());
            if (ev) void'(pe.pop_front());
            cyc++;
        end
        check("stream_budget", pd.size() + pe.size(), 0);
        pd.delete();
        pe.delete();
        idle(d);
        idle(d);
        check("scoreboard_drained", (d == 0) ? sb0.size() : sb1.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq0.delete(); mq1.delete(); sb0.delete(); sb1.delete();
        for (int k = 0; k < 2; k++) begin
            acc[k] = 0; cnt[k] = 0; uf[k] = 1'b0; se[k] = 1'b0;
        end
        #1;
        check("rst_a_out_valid", a_if.out_valid, 0);
        check("rst_a_out_first", a_if.out_first, 0);
        check("rst_a_out_last", a_if.out_last, 0);
        check("rst_a_out_data", a_if.out_data, 0);
        check("rst_a_err_count", a_if.err_count, 0);
        check("rst_a_underflow", a_if.underflow, 0);
        check("rst_a_sync_err", a_if.sync_err, 0);
        check("rst_a_in_ready", a_if.in_ready, 1);
        check("rst_b_out_valid", b_if.out_valid, 0);
        check("rst_b_out_data", b_if.out_data, 0);
        check("rst_b_err_count", b_if.err_count, 0);
        check("rst_b_underflow", b_if.underflow, 0);
        check("rst_b_sync_err", b_if.sync_err, 0);
        check("rst_b_in_ready", b_if.in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] t1d;
        logic [7:0] t1e;
        bit         ok;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0;
        a_if.err_valid = 1'b0; a_if.err_first = 1'b0; a_if.err_last = 1'b0; a_if.err = '0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_last = 1'b0;
        b_if.err_valid = 1'b0; b_if.err_first = 1'b0; b_if.err_last = 1'b0; b_if.err = '0;
        #1;
        do_reset();

        // 1-bit codeword 10110010 with flags 00100001
        t1d = 8'b10110010;
        t1e = 8'b00100001;
        for (int i = 0; i < 8; i++) begin
            pd.push_back({(i == 7), 3'b000, t1d[7-i]});
            pe.push_back({(i == 0), (i == 7), 3'b000, t1e[7-i]});
        end
        run_stream(1, 200);

        repeat (6) add_cw($urandom_range(1, 10), 30);
        run_stream(1, 1000);

        // five flagged bits into a 2-bit counter
        t1e = 8'b10110101;
        for (int i = 0; i < 8; i++) begin
            pd.push_back({(i == 7), 4'($urandom)});
            pe.push_back({(i == 0), (i == 7), 3'b000, t1e[7-i]});
        end
        run_stream(1, 200);

        // locator last one beat before data last, then a single-beat word absorbs the leftover
        for (int i = 0; i < 4; i++) pd.push_back({(i == 3), 4'($urandom)});
        for (int i = 0; i < 3; i++) pe.push_back({(i == 0), (i == 2), 4'($urandom)});
        pe.push_back({2'b11, 4'($urandom)});
        run_stream(1, 200);
        add_cw(4, 50);
        run_stream(1, 200);

        // two 4-bit codewords back to back, one all-ones nibble each
        for (int cw = 0; cw < 2; cw++) begin
            for (int i = 0; i < 4; i++) begin
                pd.push_back({(i == 3), 4'($urandom)});
                pe.push_back({(i == 0), (i == 3), (i == cw + 1) ? 4'hF : 4'h0});
            end
        end
        run_stream(0, 200);

        repeat (8) add_cw($urandom_range(1, 6), 40);
        run_stream(0, 1000);

        // fill to full, refused extra beat, push+pop while full
        for (int i = 0; i < 16; i++) step(0, 1'b1, {(i % 4 == 3), 4'($urandom)}, 1'b0, '0, ok);
        step(0, 1'b1, {1'b1, 4'h5}, 1'b0, '0, ok);
        step(0, 1'b1, {1'b1, 4'h6}, 1'b1, {2'b10, 4'($urandom)}, ok);
        idle(0);
        for (int i = 1; i < 16; i++) begin
            step(0, 1'b0, '0, 1'b1, {(i % 4 == 0), (i % 4 == 3), 4'($urandom)}, ok);
        end
        idle(0);
        idle(0);
        check("a_full_drained", sb0.size(), 0);

        // locator beat with nothing buffered
        step(0, 1'b0, '0, 1'b1, {2'b11, 4'hA}, ok);
        idle(0);
        add_cw(3, 60);
        run_stream(0, 200);

        // reset with data still buffered and a codeword half-corrected
        for (int i = 0; i < 3; i++) step(0, 1'b1, {1'b0, 4'($urandom)}, 1'b0, '0, ok);
        step(0, 1'b0, '0, 1'b1, {2'b10, 4'h3}, ok);
        idle(0);
        do_reset();
        add_cw(5, 50);
        run_stream(0, 200);
        add_cw(8, 50);
        run_stream(1, 200);

        check("final_sb_a", sb0.size(), 0);
        check("final_sb_b", sb1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
